// File: rtl/m72_irq_sched.sv
// m72_irq_sched: merges the vertical-blank start and a programmable raster-line compare into one
// vectored CPU interrupt with an acknowledge handshake, fixed priority (raster over vblank) and a
// re-arm holdoff after every acknowledge.
// Optional build macro RASTER_HPOS_PROG_EN: adds HSET and a writable horizontal compare position.
module m72_irq_sched #(
  parameter logic [7:0]  VEC_VBL     = 8'h20,
  parameter logic [7:0]  VEC_RASTER  = 8'h22,
  parameter logic [9:0]  RASTER_HPOS = 10'd448,
  parameter int unsigned HOLDOFF     = 16
) (
  input  logic        CLK_32M,
  input  logic        RESET_N,
  input  logic        CE_PIX,
  input  logic [8:0]  VE,
  input  logic [9:0]  HE,
  input  logic        VBLK,
  input  logic [15:0] D,
  input  logic        ISET,
  input  logic        CSET,
`ifdef RASTER_HPOS_PROG_EN
  input  logic        HSET,
`endif
  input  logic        IACK,
  output logic        INT_REQ,
  output logic [7:0]  INT_VEC,
  output logic [1:0]  PEND,
  output logic [1:0]  OVR
);

  localparam int unsigned CntW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e            r_state;
  logic              r_int_req;
  logic [7:0]        r_int_vec;
  logic              r_src;       // latched source: 0 vblank, 1 raster
  logic [CntW-1:0]   r_cnt;
  logic [1:0]        r_en;        // [0] vblank, [1] raster
  logic [8:0]        r_line;
  logic              r_vbl_prev;
  logic [1:0]        r_pend;
  logic [1:0]        r_ovr;

  logic [9:0]        w_hpos;
  logic              w_ev_vbl;
  logic              w_ev_ras;
  logic [1:0]        w_ev;
  logic [1:0]        w_en_clr;
  logic              w_ack;
  logic              w_abort;
  logic [1:0]        w_ack_clr;
  logic [1:0]        w_pend_avail;
  logic [1:0]        w_ovr_set;
  logic [1:0]        w_pend_d;
  logic [1:0]        w_ovr_d;

`ifdef RASTER_HPOS_PROG_EN
  logic [9:0]        r_hpos;
  logic              w_unused_d;
  assign w_hpos     = r_hpos;
  assign w_unused_d = ^D[15:10];

  // Writable horizontal compare position
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      r_hpos <= RASTER_HPOS;
    end else if (HSET) begin
      r_hpos <= D[9:0];
    end
  end
`else
  logic              w_unused_d;
  assign w_hpos     = RASTER_HPOS;
  assign w_unused_d = ^D[15:3];
`endif

  // Events only exist on pixel enables; compares use register values before this edge's writes.
  assign w_ev_vbl = CE_PIX & VBLK & ~r_vbl_prev;
  assign w_ev_ras = CE_PIX & (HE == w_hpos) & (VE == r_line);
  assign w_ev     = {w_ev_ras & r_en[1], w_ev_vbl & r_en[0]};

  assign w_en_clr  = CSET ? ~D[1:0] : 2'b00;
  assign w_ack     = (r_state == StReq) & IACK;
  assign w_abort   = (r_state == StReq) & w_en_clr[r_src];
  assign w_ack_clr = (w_ack & ~w_abort) ? (r_src ? 2'b10 : 2'b01) : 2'b00;

  // A source whose enable is being cleared this edge must not be latched.
  assign w_pend_avail = r_pend & ~w_en_clr;

  // A new event on the acknowledged source re-sets PEND instead of counting as an overrun.
  assign w_ovr_set = w_ev & r_pend & ~w_ack_clr;
  assign w_pend_d  = ((r_pend & ~w_ack_clr) | w_ev) & ~w_en_clr;
  assign w_ovr_d   = (r_ovr & ~{2{CSET & D[2]}}) | w_ovr_set;

  // Control registers, VBLK edge detector and pending/overrun flags
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      r_en       <= 2'b00;
      r_line     <= 9'd0;
      r_vbl_prev <= 1'b0;
      r_pend     <= 2'b00;
      r_ovr      <= 2'b00;
    end else begin
      if (CSET) r_en <= D[1:0];
      if (ISET) r_line <= D[8:0];
      if (CE_PIX) r_vbl_prev <= VBLK;
      r_pend <= w_pend_d;
      r_ovr  <= w_ovr_d;
    end
  end

  // Request/acknowledge/holdoff sequencer with registered INT_REQ and INT_VEC
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      r_state   <= StIdle;
      r_int_req <= 1'b0;
      r_int_vec <= VEC_VBL;
      r_src     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|w_pend_avail) begin
            r_src     <= w_pend_avail[1];
            r_int_vec <= w_pend_avail[1] ? VEC_RASTER : VEC_VBL;
            r_int_req <= 1'b1;
            r_state   <= StReq;
          end
        end
        StReq: begin
          if (w_abort) begin
            r_int_req <= 1'b0;
            r_state   <= StIdle;
          end else if (w_ack) begin
            r_int_req <= 1'b0;
            r_cnt     <= CntW'(HOLDOFF - 1);
            r_state   <= StHold;
          end
        end
        StHold: begin
          if (r_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_int_req <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign INT_REQ = r_int_req;
  assign INT_VEC = r_int_vec;
  assign PEND    = r_pend;
  assign OVR     = r_ovr;

endmodule
